key_debouncer: RTL

Parametrised multi-channel debouncer for the board's push-buttons and slide switches. It feeds the game controller with clean key levels and single-cycle press and release events. Every channel is synchronised into `clk` and sampled on a shared divided tick. A level change is accepted only after it has been stable for a programmable number of consecutive ticks. Everything runs on the system clock; no derived clocks leave the block.

---
 rtl/input_pkg.sv | 17 +
 rtl/sample_tick_gen.sv | 28 ++
 rtl/key_debouncer.sv | 106 ++++++++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared constants and helpers for the board input-conditioning blocks
// (key debouncer, sample tick generator).
package input_pkg;

  localparam int KEY_WIDTH      = 18;
  localparam int DEB_TICK_DIV   = 65536;
  localparam int DEB_STABLE_CNT = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: a one-cycle tick every DIV clk cycles, first tick on
// cycle DIV-1 after reset release. DIV = 1 gives a tick every cycle.
module sample_tick_gen
  import input_pkg::*;
#(
  parameter int DIV = DEB_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key/switch debouncer: 2-flop sync, shared sample tick, and a
// per-channel stability counter producing clean levels and press/release pulses.
module key_debouncer
  import input_pkg::*;
#(
  parameter int WIDTH      = KEY_WIDTH,
  parameter int TICK_DIV   = DEB_TICK_DIV,
  parameter int STABLE_CNT = DEB_STABLE_CNT,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             any_press
);

  localparam int CW = (clog2(STABLE_CNT + 1) < 1) ? 1 : clog2(STABLE_CNT + 1);
  localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic             tick;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] press_vec_d;
  logic             any_press_q, any_press_d;

  sample_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Synchroniser resets to the idle physical level so release never looks like a press.
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    any_press_d = |press_vec_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= INACTIVE;
      sync2_q     <= INACTIVE;
      any_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      any_press_q <= any_press_d;
    end
  end

  assign norm      = sync2_q ^ INACTIVE;
  assign any_press = any_press_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Any tick agreeing with the current level restarts the stability count.
    always_comb begin
      level_d   = level_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick) begin
        if (norm[i] == level_q) begin
          cnt_d = '0;
        end else if (int'(cnt_q) + 1 == STABLE_CNT) begin
          level_d   = norm[i];
          cnt_d     = '0;
          press_d   = norm[i];
          release_d = ~norm[i];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign press_vec_d[i] = press_d;
    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule
